// File: rtl/pixels_load.sv
// -----------------------------------------------------------------------------
// pixels_load
//   Four-entry pixel block buffer. A producer streams four pixels in (FILL),
//   then a consumer walks them out one per calc_done pulse (READY). The block
//   alternates strictly between filling and draining; there is no overlap.
//
//   Handshake: a pixel transfers on a rising clk edge where
//   pixel_valid && pixel_ready are both high. calc_done is a single-cycle
//   pulse per consumed pixel and has no ready/backpressure; a calc_done that
//   arrives while the block is not ready is dropped and flagged on calc_err
//   during the following cycle.
//
// Ports
//   clk          in   clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   clear        in   synchronous abort back to FILL, empty (slots retained)
//   pixel_in     in   [DATA_WIDTH] incoming pixel
//   pixel_valid  in   pixel_in is valid
//   pixel_ready  out  block accepts a pixel this cycle (FILL)
//   calc_done    in   consumer finished the pixel at select
//   pixel_out    out  [DATA_WIDTH] slot[select], combinational from registers
//   select       out  [2] current read index
//   block_ready  out  all four pixels loaded and readable (READY)
//   count        out  [3] loaded, not yet consumed pixels, 0..4
//   calc_err     out  one-cycle flag: calc_done seen while not block_ready
//   dbg_state    out  current FSM state (0 = FILL, 1 = READY)
// -----------------------------------------------------------------------------
module pixels_load #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic                  calc_done,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [1:0]            select,
    output logic                  block_ready,
    output logic [2:0]            count,
    output logic                  calc_err,
    output logic                  dbg_state
);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_slot [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic                  r_calc_err;

    state_t                w_state_nxt;
    logic [1:0]            w_wr_ptr_nxt;
    logic [1:0]            w_rd_ptr_nxt;
    logic [2:0]            w_count_nxt;
    logic                  w_calc_err_nxt;
    logic                  w_wr_en;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_calc_err_nxt = 1'b0;
        w_wr_en        = 1'b0;

        if (clear) begin
            // Abort wins over everything; slot contents are deliberately kept.
            w_state_nxt  = ST_FILL;
            w_wr_ptr_nxt = 2'd0;
            w_rd_ptr_nxt = 2'd0;
            w_count_nxt  = 3'd0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (pixel_valid) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 2'd1;
                        w_count_nxt  = r_count + 3'd1;
                        if (r_wr_ptr == 2'd3) begin
                            w_state_nxt = ST_READY;
                        end
                    end
                    // Nothing to consume yet: drop the pulse and flag it.
                    if (calc_done) begin
                        w_calc_err_nxt = 1'b1;
                    end
                end
                ST_READY: begin
                    // pixel_valid is ignored here; pixel_ready is low.
                    if (calc_done) begin
                        w_rd_ptr_nxt = r_rd_ptr + 2'd1;
                        w_count_nxt  = r_count - 3'd1;
                        if (r_rd_ptr == 2'd3) begin
                            w_state_nxt = ST_FILL;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and pointer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_FILL;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_calc_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_calc_err <= w_calc_err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Pixel storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_slot[r_wr_ptr] <= pixel_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pixel_ready = (r_state == ST_FILL);
    assign block_ready = (r_state == ST_READY);
    assign select      = r_rd_ptr;
    assign pixel_out   = r_slot[r_rd_ptr];
    assign count       = r_count;
    assign calc_err    = r_calc_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pixels_load.sv
// -----------------------------------------------------------------------------
// tb_pixels_load
//   Directed scenarios followed by a randomized run, all checked against a
//   reference model that tracks how many pixels were loaded and how many were
//   consumed, plus a copy of the stored pixel values.
// -----------------------------------------------------------------------------
module tb_pixels_load;

    localparam int DW = 8;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic          clear = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic          calc_done = 1'b0;
    logic [DW-1:0] pixel_out;
    logic [1:0]    select;
    logic          block_ready;
    logic [2:0]    count;
    logic          calc_err;
    logic          dbg_state;

    pixels_load #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .calc_done   (calc_done),
        .pixel_out   (pixel_out),
        .select      (select),
        .block_ready (block_ready),
        .count       (count),
        .calc_err    (calc_err),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // -------------------------------------------------------------------------
    // Reference model: the block is "full" once four pixels have been loaded;
    // it drains one pixel per calc_done and empties after the fourth.
    // -------------------------------------------------------------------------
    logic [DW-1:0] m_mem [4];
    int            m_loaded;
    int            m_consumed;
    logic          m_err;

    function automatic logic m_full();
        return (m_loaded == 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_loaded   = 0;
        m_consumed = 0;
        m_err      = 1'b0;
    endtask

    task automatic model_clock(input logic v, input logic [DW-1:0] p,
                               input logic d, input logic c);
        if (c) begin
            m_loaded   = 0;
            m_consumed = 0;
            m_err      = 1'b0;
        end else if (!m_full()) begin
            m_err = d;
            if (v) begin
                m_mem[m_loaded] = p;
                m_loaded++;
            end
        end else begin
            m_err = 1'b0;
            if (d) begin
                m_consumed++;
                if (m_consumed == 4) begin
                    m_loaded   = 0;
                    m_consumed = 0;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard comparisons
    // -------------------------------------------------------------------------
    task automatic check_outputs(input string tag);
        logic [1:0]    e_sel;
        logic [2:0]    e_cnt;
        logic [DW-1:0] e_pix;
        e_sel = m_full() ? 2'(m_consumed) : 2'd0;
        e_cnt = 3'(m_loaded - m_consumed);
        e_pix = m_mem[e_sel];

        checks++;
        assert (pixel_ready === !m_full()) else begin
            errors++;
            $error("FAIL %s pixel_ready got %b exp %b", tag, pixel_ready, !m_full());
        end
        checks++;
        assert (block_ready === m_full()) else begin
            errors++;
            $error("FAIL %s block_ready got %b exp %b", tag, block_ready, m_full());
        end
        checks++;
        assert (select === e_sel) else begin
            errors++;
            $error("FAIL %s select got %0d exp %0d", tag, select, e_sel);
        end
        checks++;
        assert (count === e_cnt) else begin
            errors++;
            $error("FAIL %s count got %0d exp %0d", tag, count, e_cnt);
        end
        checks++;
        assert (pixel_out === e_pix) else begin
            errors++;
            $error("FAIL %s pixel_out got %h exp %h", tag, pixel_out, e_pix);
        end
        checks++;
        assert (calc_err === m_err) else begin
            errors++;
            $error("FAIL %s calc_err got %b exp %b", tag, calc_err, m_err);
        end
        checks++;
        assert (dbg_state === m_full()) else begin
            errors++;
            $error("FAIL %s dbg_state got %b exp %b", tag, dbg_state, m_full());
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver: apply inputs, take one rising edge, then check 1ns later
    // -------------------------------------------------------------------------
    task automatic step(input string tag, input logic v, input logic [DW-1:0] p,
                        input logic d, input logic c);
        pixel_valid = v;
        pixel_in    = p;
        calc_done   = d;
        clear       = c;
        @(posedge clk);
        model_clock(v, p, d, c);
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, "_during"});
        pixel_valid = 1'b0;
        calc_done   = 1'b0;
        clear       = 1'b0;
        @(posedge clk);
        #1;
        check_outputs({tag, "_held"});
        n_rst = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [DW-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        model_reset();
        #3;
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_edge");
        n_rst = 1'b1;

        // Back-to-back load of four pixels
        for (int i = 0; i < 4; i++) step("load", 1'b1, vals[i], 1'b0, 1'b0);

        // Drain with pixel_valid held high and 0xFF on the bus
        for (int i = 0; i < 4; i++) step("drain_busy", 1'b1, 8'hFF, 1'b1, 1'b0);
        step("after_drain", 1'b0, 8'h00, 1'b0, 1'b0);

        // calc_done in FILL after two loads
        step("fill2_a", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("fill2_b", 1'b1, 8'hA2, 1'b0, 1'b0);
        step("early_done", 1'b0, 8'h00, 1'b1, 1'b0);
        step("early_done_post", 1'b0, 8'h00, 1'b0, 1'b0);

        // Same-cycle valid + done in FILL: write happens and error flags
        step("fill_both", 1'b1, 8'hA3, 1'b1, 1'b0);

        // clear with count=3 and pixel_valid high, then reload
        step("clear", 1'b1, 8'hEE, 1'b0, 1'b1);
        step("reload0", 1'b1, 8'h5A, 1'b0, 1'b0);
        step("reload1", 1'b1, 8'h5B, 1'b0, 1'b0);
        step("reload2", 1'b1, 8'h5C, 1'b0, 1'b0);
        step("reload3", 1'b1, 8'h5D, 1'b0, 1'b0);

        // Two consumes then asynchronous reset mid-drain
        step("pre_rst_d0", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pre_rst_d1", 1'b0, 8'h00, 1'b1, 1'b0);
        async_reset("mid_drain_rst");
        step("post_rst_load", 1'b1, 8'h77, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 DW'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixels_load.md
PIXELS_LOAD -- requirements
Module: pixels_load

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have clear  input  1  synchronous abort; returns block to FILL, empty.
REQ-005 SHALL have pixel_in  input  DATA_WIDTH  incoming pixel data.
REQ-006 SHALL have pixel_valid  input  1  producer asserts pixel_in valid.
REQ-007 SHALL have pixel_ready  output  1  block can accept a pixel this cycle.
REQ-008 SHALL have calc_done  input  1  consumer finished current pixel; one pulse per pixel.
REQ-009 SHALL have pixel_out  output  DATA_WIDTH  pixel at current read index.
REQ-010 SHALL have select  output  2  current read index 0..3.
REQ-011 SHALL have block_ready  output  1  all four pixels loaded and readable.
REQ-012 SHALL have count  output  3  number of loaded, unconsumed pixels 0..4.
REQ-013 SHALL have calc_err  output  1  one-cycle pulse on calc_done while not block_ready.

Function
REQ-014 SHALL store four DATA_WIDTH entries (slots 0..3), a 2-bit write pointer wr_ptr and a 2-bit read pointer rd_ptr.
REQ-015 SHALL implement states FILL and READY; only these two encodings reachable.
REQ-016 In FILL: pixel_ready=1, block_ready=0; transfer occurs when pixel_valid && pixel_ready at a rising edge.
REQ-017 On transfer: slot[wr_ptr] <= pixel_in, wr_ptr <= wr_ptr+1 (mod 4), count <= count+1.
REQ-018 On transfer with wr_ptr==3: state <= READY, wr_ptr wraps to 0, count becomes 4; block_ready=1 the following cycle.
REQ-019 In READY: pixel_ready=0, block_ready=1; pixel_valid ignored, no slot written, no error raised.
REQ-020 In READY, on calc_done: rd_ptr <= rd_ptr+1 (mod 4), count <= count-1.
REQ-021 In READY, on calc_done with rd_ptr==3: state <= FILL, rd_ptr wraps to 0, count becomes 0; pixel_ready=1 the following cycle.
REQ-022 select SHALL equal rd_ptr at all times; pixel_out SHALL equal slot[rd_ptr], combinational from registers (zero-cycle read latency).
REQ-023 calc_done in FILL SHALL not change rd_ptr or count and SHALL pulse calc_err for exactly the next cycle.
REQ-024 Same-cycle pixel_valid and calc_done: only the one legal in current state acts (FILL: write + calc_err; READY: consume).
REQ-025 clear SHALL take priority over all other inputs: state <= FILL, wr_ptr, rd_ptr, count <= 0, calc_err <= 0; slot contents retained.
REQ-026 Minimum full cycle: 4 transfer cycles + 4 calc_done cycles; back-to-back pixel_valid and calc_done SHALL be accepted every cycle.
REQ-027 count SHALL never exceed 4 nor underflow below 0.

Reset
REQ-028 On n_rst low, asynchronously: state=FILL, wr_ptr=0, rd_ptr=0, count=0, calc_err=0, all slots=0.
REQ-029 During and immediately after reset: pixel_ready=1, block_ready=0, select=0, pixel_out=0.
REQ-030 Reset mid-fill or mid-drain SHALL discard progress; next transfer writes slot 0.

Verification
REQ-031 Load 0x11,0x22,0x33,0x44 back-to-back -> block_ready=1 next cycle, count=4, select=0, pixel_out=0x11, pixel_ready=0.
REQ-032 From READY, four consecutive calc_done pulses -> pixel_out 0x11,0x22,0x33,0x44 at select 0..3; then FILL, count=0, select=0.
REQ-033 pixel_valid held high in READY with pixel_in=0xFF -> slots unchanged, pixel_out sequence still 0x11..0x44.
REQ-034 calc_done pulse in FILL after two loads -> calc_err=1 one cycle, count stays 2, select stays 0.
REQ-035 clear asserted with count=3 and pixel_valid=1 -> next cycle count=0, FILL, wr_ptr=0; next transfer lands in slot 0.
REQ-036 n_rst pulsed low after two calc_done in READY -> immediately select=0, count=0, block_ready=0, pixel_ready=1, pixel_out=0.
